simple_router_fifo: RTL and testbench
=====================================

# simple_router_fifo

Parametrised 1-to-N packet router with per-output buffering and valid/ready flow control. A single input stream of words is steered to one of `NUM_PORTS` outputs by an address field. Each output has its own FIFO, so a stalled consumer blocks only traffic addressed to it. It is the sequential, back-pressured next generation of the combinational address decoder and sits between a single producer and several independent consumers.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of one data word
- `NUM_PORTS`, 4, number of outputs; 2..16
- `DEPTH`, 4, entries per output FIFO; power of 2, at least 2
- `ADDR_WIDTH`, `$clog2(NUM_PORTS)`, width of `addr`; derived, not overridden

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `din`  in  DATA_WIDTH  input word
- `din_valid`  in  1  `din`/`addr` valid
- `din_ready`  out  1  router can take the current word
- `addr`  in  ADDR_WIDTH  destination port index
- `dout`  out  NUM_PORTS*DATA_WIDTH  port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH]
- `dout_valid`  out  NUM_PORTS  per-port head-of-FIFO valid
- `dout_ready`  in  NUM_PORTS  per-port consumer ready
- `drop_count`  out  16  count of words dropped for an out-of-range `addr`; saturating

## Operation
- Per port p: a FIFO of `DEPTH` entries, with `wr_ptr`, `rd_ptr` and `count` (width `$clog2(DEPTH)+1`). Pointers wrap modulo `DEPTH`.
- `din_ready`:
  - For `addr < NUM_PORTS`: equals `count[addr] != DEPTH`. It depends only on fullness, never on same-cycle `dout_ready`.
  - For `addr >= NUM_PORTS`: 1.
- Input accept: `din_valid & din_ready` at a rising edge.
  - In-range `addr`: `din` is written to FIFO[addr] and that FIFO's `wr_ptr` and `count` increment.
  - Out-of-range `addr`: the word is discarded and `drop_count` increments, saturating at 16'hFFFF.
- Per port:
  - `dout_valid[p] = (count[p] != 0)`.
  - `dout[p]` = FIFO[p] head entry when valid, otherwise all zeros.
- Pop: `dout_valid[p] & dout_ready[p]` at a rising edge advances `rd_ptr[p]` and decrements `count[p]`.
- Push and pop on the same port in the same cycle: `count` is unchanged and both pointers advance. This is legal in every non-full and non-empty state.
- A push to port p is independent of pops on other ports. Only one push can happen per cycle.
- Order is preserved per port. No ordering is guaranteed across ports.
- `dout_ready` with `dout_valid` low is ignored.
- `din`/`addr` may change freely while `din_valid` is low. While `din_valid & !din_ready`, the producer holds `din`/`addr` stable.

## Timing
- Reset, asynchronous, taking effect immediately:
  - All `count`, `wr_ptr`, `rd_ptr` = 0.
  - `drop_count` = 0.
  - `dout_valid` = 0 and `dout` = 0.
  - `din_ready` = 1.
- Reset asserted mid-transfer discards all buffered words. Nothing is accepted or popped while `reset` is high.
- Latency: a word accepted at edge N gives `dout_valid[p]=1` with that word on `dout[p]` after edge N, i.e. in the cycle following the accept. This is a 1-cycle minimum when the FIFO was empty.
- Throughput: 1 word/cycle in. Each port sustains 1 word/cycle out when `dout_ready[p]` is held high.
- Full: when `count[p]==DEPTH`, `din_ready` is low only while `addr==p`. A pop on p in that cycle does not raise `din_ready` until the next cycle.
- Empty: a pop is impossible. A push into an empty FIFO is visible next cycle; there is no same-cycle bypass.
- `drop_count` updates on the accepting edge and holds at 16'hFFFF once saturated.

## Test plan
- Reset and basic routing (defaults):
  - Check all outputs are 0 and `din_ready`=1 after reset.
  - Send 32'hA0, A1, A2, A3 to addr 0,1,2,3 with all `dout_ready`=1.
  - Each `dout[p]` shows its word exactly one cycle after accept, and `dout_valid` pulses for one cycle.
- Fill and back-pressure:
  - Hold `dout_ready[2]`=0 and push 5 words 32'h10..14 to addr 2.
  - The first 4 are accepted. `din_ready`=0 on the 5th.
  - Switching `addr` to 1 raises `din_ready` in the same cycle.
- Drain order and simultaneous push/pop:
  - With FIFO 2 full, raise `dout_ready[2]`: 32'h10,11,12,13 emerge in order.
  - Then stream continuous pushes and pops to port 2 for 20 cycles: `count` stays constant and no words are lost.
- Pointer wrap:
  - Push and pop 3*DEPTH+1 sequential words through port 0 with random `dout_ready` stalls.
  - The output sequence matches the input exactly.
- Out-of-range drop (`NUM_PORTS`=3):
  - Send 5 words to addr 3: all accepted, no `dout_valid`, `drop_count`=5.
  - Force 70000 drops: `drop_count` = 16'hFFFF.
- Reset mid-operation:
  - With ports 0 and 1 holding 2 words each, assert `reset` between edges.
  - `dout_valid` drops immediately, and after release all FIFOs are empty with `din_ready`=1.

Source files
------------

// File: rtl/simple_router_fifo.sv
// simple_router_fifo: 1-to-N word router with a DEPTH-entry FIFO per output port.
// Words whose addr names no port are discarded and counted in a saturating counter.
module simple_router_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DATA_WIDTH-1:0]           din,
   input  logic                            din_valid,
   output logic                            din_ready,
   input  logic [ADDR_WIDTH-1:0]           addr,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
   output logic [NUM_PORTS-1:0]            dout_valid,
   input  logic [NUM_PORTS-1:0]            dout_ready,
   output logic [15:0]                     drop_count
);

   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
   localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q    [NUM_PORTS][DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q [NUM_PORTS];
   logic [PTR_WIDTH-1:0]  rd_ptr_q [NUM_PORTS];
   logic [CNT_WIDTH-1:0]  count_q  [NUM_PORTS];
   logic [15:0]           drop_q;

   logic [NUM_PORTS-1:0]  hit;
   logic [NUM_PORTS-1:0]  full;
   logic [NUM_PORTS-1:0]  push;
   logic [NUM_PORTS-1:0]  pop;
   logic                  drop;

   // Ready depends only on the fullness of the addressed FIFO, never on same-cycle pops.
   always_comb begin
      din_ready = 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
         hit[p]  = (addr == ADDR_WIDTH'(p));
         full[p] = (count_q[p] == FULL_CNT);
         push[p] = din_valid & hit[p] & ~full[p];
         pop[p]  = (count_q[p] != '0) & dout_ready[p];
         if (hit[p] && full[p]) begin
            din_ready = 1'b0;
         end
      end
      drop = din_valid & ~(|hit);
   end

   always_comb begin
      dout       = '0;
      dout_valid = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         dout_valid[p] = (count_q[p] != '0);
         if (dout_valid[p]) begin
            dout[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[p][rd_ptr_q[p]];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_q[p] <= '0;
            rd_ptr_q[p] <= '0;
            count_q[p]  <= '0;
         end
         drop_q <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) begin
               wr_ptr_q[p] <= wr_ptr_q[p] + 1'b1;
            end
            if (pop[p]) begin
               rd_ptr_q[p] <= rd_ptr_q[p] + 1'b1;
            end
            if (push[p] && !pop[p]) begin
               count_q[p] <= count_q[p] + 1'b1;
            end else if (pop[p] && !push[p]) begin
               count_q[p] <= count_q[p] - 1'b1;
            end
         end
         if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
         end
      end
   end

   // Storage needs no reset: dout is gated by count, which is reset.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (push[p]) begin
            mem_q[p][wr_ptr_q[p]] <= din;
         end
      end
   end

   assign drop_count = drop_q;

endmodule

// File: tb/tb_simple_router_fifo.sv
// Self-checking bench for simple_router_fifo: queue-based scoreboard on a 4-port instance,
// plus a 3-port instance exercising out-of-range drops and counter saturation.
module tb_simple_router_fifo;

   localparam int NP    = 4;
   localparam int DEPTH = 4;
   localparam int DW    = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0]    din        = '0;
   logic             din_valid  = 1'b0;
   logic [1:0]       addr       = '0;
   logic             din_ready;
   logic [NP*DW-1:0] dout;
   logic [NP-1:0]    dout_valid;
   logic [NP-1:0]    dout_ready = '1;
   logic [15:0]      drop_count;

   logic             rst3   = 1'b1;
   logic [DW-1:0]    din3   = '0;
   logic             valid3 = 1'b0;
   logic [1:0]       addr3  = '0;
   logic             ready3;
   logic [3*DW-1:0]  dout3;
   logic [2:0]       dv3;
   logic [2:0]       dr3    = '0;
   logic [15:0]      drop3;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] q [NP][$];
   bit rand_rdy0 = 1'b0;
   bit done3     = 1'b0;

   simple_router_fifo u_dut (
      .clk        (clk),
      .reset      (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .addr       (addr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .drop_count (drop_count)
   );

   simple_router_fifo #(.NUM_PORTS(3)) u_dut3 (
      .clk        (clk),
      .reset      (rst3),
      .din        (din3),
      .din_valid  (valid3),
      .din_ready  (ready3),
      .addr       (addr3),
      .dout       (dout3),
      .dout_valid (dv3),
      .dout_ready (dr3),
      .drop_count (drop3)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus; caller sits just after a rising edge.
   task automatic cycle(input bit v, input int a, input logic [DW-1:0] d, output bit acc);
      bit exp_rdy;
      din_valid = v;
      addr      = a[1:0];
      din       = d;
      if (rand_rdy0) dout_ready[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_rdy = !(q[a].size() == DEPTH);
      check("din_ready", din_ready, exp_rdy);
      acc = v && exp_rdy;
      @(posedge clk);
      if (acc) q[a].push_back(d);
      #1;
   endtask

   task automatic send(input int a, input logic [DW-1:0] d);
      bit acc = 1'b0;
      for (int n = 0; n < 40 && !acc; n++) cycle(1'b1, a, d, acc);
      check("send accepted", acc, 1);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, acc);
   endtask

   // Monitor: compares every port against the head of its expected queue each cycle.
   initial begin : monitor
      bit pop [NP];
      forever begin
         @(negedge clk);
         for (int p = 0; p < NP; p++) begin
            pop[p] = 1'b0;
            if (!rst) begin
               check($sformatf("dout_valid[%0d]", p), dout_valid[p], q[p].size() != 0);
               if (q[p].size() != 0) begin
                  check($sformatf("dout[%0d]", p), dout[p*DW +: DW], q[p][0]);
                  pop[p] = dout_ready[p];
               end else begin
                  check($sformatf("dout[%0d] idle", p), dout[p*DW +: DW], 0);
               end
            end
         end
         @(posedge clk);
         for (int p = 0; p < NP; p++) begin
            if (pop[p] && !rst) void'(q[p].pop_front());
         end
      end
   end

   initial begin : main
      #1;
      check("reset dout", dout, 0);
      check("reset dout_valid", dout_valid, 0);
      check("reset din_ready", din_ready, 1);
      check("reset drop_count", drop_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic routing, consumers always ready.
      send(0, 32'hA0);
      send(1, 32'hA1);
      send(2, 32'hA2);
      send(3, 32'hA3);
      idle(3);

      // Fill port 2 and check back-pressure is per-address.
      dout_ready = 4'b1011;
      for (int i = 0; i < 4; i++) send(2, 32'h10 + i);
      din_valid = 1'b1;
      addr      = 2'd2;
      din       = 32'h14;
      @(negedge clk);
      check("full din_ready", din_ready, 0);
      addr = 2'd1;
      #1;
      check("switch din_ready", din_ready, 1);
      @(posedge clk);
      q[1].push_back(32'h14);
      #1;

      // Drain in order while streaming new words into port 2.
      dout_ready = 4'b1111;
      for (int i = 0; i < 20; i++) send(2, 32'h100 + i);
      idle(5);

      // Pointer wrap with random stalls on port 0.
      rand_rdy0 = 1'b1;
      for (int i = 0; i < 3*DEPTH+1; i++) send(0, 32'h200 + i);
      for (int n = 0; n < 100 && q[0].size() != 0; n++) idle(1);
      rand_rdy0  = 1'b0;
      dout_ready = '1;
      idle(2);

      // Reset with words buffered on ports 0 and 1.
      dout_ready = 4'b1100;
      send(0, 32'h300);
      send(0, 32'h301);
      send(1, 32'h310);
      send(1, 32'h311);
      idle(1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid reset dout_valid", dout_valid, 0);
      check("mid reset dout", dout, 0);
      check("mid reset din_ready", din_ready, 1);
      for (int p = 0; p < NP; p++) q[p].delete();
      din_valid = 1'b1;
      addr      = 2'd0;
      din       = 32'h3FF;
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      rst        = 1'b0;
      dout_ready = '1;
      idle(3);
      send(0, 32'h400);
      idle(2);
      check("main drop_count", drop_count, 0);

      for (int n = 0; n < 80000 && !done3; n++) @(posedge clk);
      check("dut3 finished", done3, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : drop_test
      int exp_drop = 0;
      int sat;
      #1;
      check("dut3 reset drop_count", drop3, 0);
      check("dut3 reset din_ready", ready3, 1);
      @(posedge clk);
      #1;
      rst3 = 1'b0;

      for (int i = 0; i < 5; i++) begin
         valid3 = 1'b1;
         addr3  = 2'd3;
         din3   = 32'h500 + i;
         @(negedge clk);
         check("dut3 drop din_ready", ready3, 1);
         @(posedge clk);
         exp_drop++;
         #1;
         check("dut3 drop dout_valid", dv3, 0);
      end
      valid3 = 1'b0;
      check("dut3 drop_count 5", drop3, exp_drop);

      addr3  = 2'd2;
      din3   = 32'h5A5A;
      valid3 = 1'b1;
      @(negedge clk);
      check("dut3 in-range din_ready", ready3, 1);
      @(posedge clk);
      #1;
      valid3 = 1'b0;
      @(negedge clk);
      check("dut3 port2 valid", dv3, 3'b100);
      check("dut3 port2 data", dout3[2*DW +: DW], 32'h5A5A);
      check("dut3 in-range no drop", drop3, exp_drop);
      dr3 = 3'b100;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("dut3 port2 popped", dv3, 0);

      valid3 = 1'b1;
      addr3  = 2'd3;
      for (int i = 0; i < 70000; i++) begin
         @(posedge clk);
         exp_drop++;
         #1;
         if (exp_drop == 65000) check("dut3 drop_count mid", drop3, exp_drop);
      end
      sat = (exp_drop > 65535) ? 65535 : exp_drop;
      check("dut3 drop_count saturated", drop3, sat);
      @(posedge clk);
      #1;
      valid3 = 1'b0;
      check("dut3 drop_count holds", drop3, 16'hFFFF);
      done3 = 1'b1;
   end

endmodule
